// File: rtl/weight_stream_sink_ram.sv
// weight_stream_sink_ram
// Receive side of the parameter-streaming protocol. Incoming valid/ready
// weight beats are written sequentially into an on-chip RAM. A ROM-style
// read port with 2-cycle latency lets weight sources replay the tensor.

module weight_stream_sink_ram #(
   parameter int PRECISION_0 = 16,
   parameter int PAR         = 1,
   parameter int DEPTH       = 32,
   parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PRECISION_0-1:0]     data_in [PAR],
   input  logic                       data_in_valid,
   output logic                       data_in_ready,
   input  logic                       data_in_last,
   input  logic                       reload,
   output logic                       loaded,
   output logic                       len_err,
   output logic [ADDR_WIDTH-1:0]      beat_count,
   input  logic [ADDR_WIDTH-1:0]      address0,
   input  logic                       ce0,
   output logic [PRECISION_0*PAR-1:0] q0
);

   localparam int WORD_W = PRECISION_0 * PAR;
   localparam int IDX_W  = $clog2(DEPTH);

   // Constants held at the address width so every compare is width-matched.
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX_A = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      LOAD = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic [WORD_W-1:0]       packed_beat;
   logic [WORD_W-1:0]       ram [DEPTH];
   logic [WORD_W-1:0]       r1;
   logic                    accept;
   logic                    at_end;
   logic                    load_done;

   // The sink only takes beats while loading, and never during a reload or reset cycle.
   assign data_in_ready = (state == LOAD) && !reload && !rst;
   assign accept        = data_in_valid && data_in_ready;
   assign at_end        = (wr_ptr == LAST_IDX_A);
   assign load_done     = accept && (at_end || data_in_last);

   // Pack the unpacked element array into one RAM word, element j at the j-th slice.
   always_comb begin
      packed_beat = '0;
      for (int j = 0; j < PAR; j++) begin
         packed_beat[PRECISION_0*j +: PRECISION_0] = data_in[j];
      end
   end

   // Next-state logic: reload always wins, otherwise the tensor closes on the last slot or on last.
   always_comb begin
      next_state = state;
      if (reload) begin
         next_state = LOAD;
      end else if ((state == LOAD) && load_done) begin
         next_state = FULL;
      end
   end

   // State register plus the load bookkeeping that travels with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         wr_ptr     <= '0;
         beat_count <= '0;
         loaded     <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         state <= next_state;
         if (reload) begin
            wr_ptr     <= '0;
            beat_count <= '0;
            loaded     <= 1'b0;
            len_err    <= 1'b0;
         end else if (accept) begin
            if (beat_count != DEPTH_A) begin
               beat_count <= beat_count + 1'b1;
            end
            if (load_done) begin
               wr_ptr <= '0;
               loaded <= 1'b1;
               // A mismatch is last arriving early, or the final slot filling without last.
               if (at_end != data_in_last) begin
                  len_err <= 1'b1;
               end
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
      end
   end

   // Weight storage; never reset so a reload or reset keeps whatever was written.
   always_ff @(posedge clk) begin
      if (accept) begin
         ram[wr_ptr[IDX_W-1:0]] <= packed_beat;
      end
   end

   // First read stage: non-blocking read of ram gives read-first behaviour on collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1 <= '0;
      end else if (ce0) begin
         r1 <= (address0 < DEPTH_A) ? ram[address0[IDX_W-1:0]] : '0;
      end
   end

   // Second read stage: output register that holds whenever ce0 is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         q0 <= '0;
      end else if (ce0) begin
         q0 <= r1;
      end
   end

endmodule
